// File: rtl/sr_seq_pkg.sv
// sr_seq_pkg: shared state encoding and counter-width helpers for sr_load_sequencer
package sr_seq_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_e;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
  function automatic int gap_w(input int gap);
    return (gap < 1) ? 1 : $clog2(gap + 1);
  endfunction
endpackage

// File: rtl/sr_load_sequencer_piso_shifter.sv
// piso_shifter: hold register with parallel load, one-bit advance and selectable bit order
//   clk, reset : clock, synchronous active-high reset
//   load_i     : capture data_i into the hold register
//   adv_i      : advance the hold register by one bit
//   data_i     : parallel word
//   bit_o      : bit currently presented
module piso_shifter #(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             bit_o
);
  logic [WIDTH-1:0] hold_q;
  always_ff @(posedge clk)
    if (reset) hold_q <= '0;
    else if (load_i) hold_q <= data_i;
    else if (adv_i) hold_q <= LSB_FIRST ? (hold_q >> 1) : (hold_q << 1);
  assign bit_o = LSB_FIRST ? hold_q[0] : hold_q[WIDTH-1];
endmodule

// File: rtl/sr_load_sequencer.sv
// sr_load_sequencer: serializes handshaken parallel words into a downstream serial-in shift register
//   clk, reset   : clock, synchronous active-high reset
//   data_i       : word to serialize, sampled on handshake
//   valid_i      : producer has a word
//   ready_o      : sequencer can accept a word
//   x_o          : serial bit for the downstream register
//   shift_en_o   : downstream register captures x_o on the next edge
//   word_done_o  : downstream register now holds the full word
//   busy_o       : word in flight (SHIFT, DONE or GAP)
//   count_o      : bits of the current word already presented
module sr_load_sequencer
  import sr_seq_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP       = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     x_o,
  output logic                     shift_en_o,
  output logic                     word_done_o,
  output logic                     busy_o,
  output logic [cnt_w(WIDTH)-1:0]  count_o
);
  localparam int CW = cnt_w(WIDTH);
  localparam int GW = gap_w(GAP);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [GW-1:0] GLAST = GW'((GAP > 0) ? GAP - 1 : 0);
  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gap_q;
  logic          accept;
  logic          cur_bit;
  assign accept = valid_i && ready_o;
  piso_shifter #(.WIDTH(WIDTH), .LSB_FIRST(LSB_FIRST)) u_piso (
    .clk    (clk),
    .reset  (reset),
    .load_i (accept),
    .adv_i  (state_q == SHIFT),
    .data_i (data_i),
    .bit_o  (cur_bit)
  );
  // The GAP parameter shadows the imported state name, so that state is package-qualified.
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (accept) begin
            state_q <= SHIFT;
            cnt_q   <= '0;
          end
        SHIFT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          gap_q   <= '0;
          state_q <= (GAP > 0) ? sr_seq_pkg::GAP : IDLE;
          cnt_q   <= (GAP > 0) ? FULL : '0;
        end
        default: begin
          gap_q <= gap_q + 1'b1;
          if (gap_q == GLAST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
      endcase
    end
  assign ready_o     = (state_q == IDLE) && !reset;
  assign shift_en_o  = state_q == SHIFT;
  assign x_o         = (state_q == SHIFT) && cur_bit;
  assign word_done_o = state_q == DONE;
  assign busy_o      = state_q != IDLE;
  assign count_o     = cnt_q;
endmodule

// File: tb/tb_sr_load_sequencer.sv
// tb_sr_load_sequencer: directed checks of three sequencer configurations feeding 4-bit shift registers
module tb_sr_load_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] data0 = '0, data1 = '0, data2 = '0;
  logic valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0;
  logic ready0, x0, en0, wd0, busy0;
  logic ready1, x1, en1, wd1, busy1;
  logic ready2, x2, en2, wd2, busy2;
  logic [2:0] cnt0, cnt1, cnt2;
  logic [3:0] sr0, sr1, sr2;
  int cmp = 0;
  int err = 0;
  int cyc = 0;
  int acc_last = 0, acc_prev = 0;

  always #5 clk = ~clk;

  sr_load_sequencer #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP(1)) dut0 (
    .clk(clk), .reset(reset), .data_i(data0), .valid_i(valid0), .ready_o(ready0),
    .x_o(x0), .shift_en_o(en0), .word_done_o(wd0), .busy_o(busy0), .count_o(cnt0));
  sr_load_sequencer #(.WIDTH(4), .LSB_FIRST(1'b1), .GAP(1)) dut1 (
    .clk(clk), .reset(reset), .data_i(data1), .valid_i(valid1), .ready_o(ready1),
    .x_o(x1), .shift_en_o(en1), .word_done_o(wd1), .busy_o(busy1), .count_o(cnt1));
  sr_load_sequencer #(.WIDTH(4), .LSB_FIRST(1'b0), .GAP(0)) dut2 (
    .clk(clk), .reset(reset), .data_i(data2), .valid_i(valid2), .ready_o(ready2),
    .x_o(x2), .shift_en_o(en2), .word_done_o(wd2), .busy_o(busy2), .count_o(cnt2));

  // Downstream serial-in shift registers: MSB-first, x_i shifts into bit 0.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      sr0 <= '0;
      sr1 <= '0;
      sr2 <= '0;
    end else begin
      if (en0) sr0 <= {sr0[2:0], x0};
      if (en1) sr1 <= {sr1[2:0], x1};
      if (en2) sr2 <= {sr2[2:0], x2};
    end
    if (valid0 && ready0) begin
      acc_prev <= acc_last;
      acc_last <= cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    cmp++; if (ready0 !== 1'b0) begin err++; $display("FAIL rst_ready_held got %b want 0", ready0); end
    reset = 1'b0;
    #1;
    cmp++; if (ready0 !== 1'b1) begin err++; $display("FAIL rst_ready got %b want 1", ready0); end
    cmp++; if (busy0 !== 1'b0) begin err++; $display("FAIL rst_busy got %b want 0", busy0); end
    cmp++; if (x0 !== 1'b0) begin err++; $display("FAIL rst_x got %b want 0", x0); end
    cmp++; if (en0 !== 1'b0) begin err++; $display("FAIL rst_en got %b want 0", en0); end
    cmp++; if (cnt0 !== 3'd0) begin err++; $display("FAIL rst_count got %0d want 0", cnt0); end
    cmp++; if (wd0 !== 1'b0) begin err++; $display("FAIL rst_done got %b want 0", wd0); end
  endtask

  task automatic test_msb();
    logic [3:0] exp_x = 4'b1011;
    data0 = 4'b1011;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++; if (x0 !== exp_x[3-i]) begin err++; $display("FAIL msb_x%0d got %b want %b", i, x0, exp_x[3-i]); end
      cmp++; if (en0 !== 1'b1) begin err++; $display("FAIL msb_en%0d got %b want 1", i, en0); end
      cmp++; if (cnt0 !== 3'(i)) begin err++; $display("FAIL msb_count%0d got %0d want %0d", i, cnt0, i); end
      cmp++; if (ready0 !== 1'b0) begin err++; $display("FAIL msb_ready%0d got %b want 0", i, ready0); end
      step();
    end
    cmp++; if (wd0 !== 1'b1) begin err++; $display("FAIL msb_done got %b want 1", wd0); end
    cmp++; if (sr0 !== 4'b1011) begin err++; $display("FAIL msb_sr got %b want 1011", sr0); end
    cmp++; if (cnt0 !== 3'd4) begin err++; $display("FAIL msb_done_count got %0d want 4", cnt0); end
    cmp++; if ({en0, x0} !== 2'b00) begin err++; $display("FAIL msb_done_en_x got %b want 00", {en0, x0}); end
    step();
    cmp++; if ({wd0, busy0, ready0} !== 3'b010) begin err++; $display("FAIL msb_gap got %b want 010", {wd0, busy0, ready0}); end
    cmp++; if (cnt0 !== 3'd4) begin err++; $display("FAIL msb_gap_count got %0d want 4", cnt0); end
    step();
    cmp++; if ({busy0, ready0} !== 2'b01) begin err++; $display("FAIL msb_idle got %b want 01", {busy0, ready0}); end
    cmp++; if (cnt0 !== 3'd0) begin err++; $display("FAIL msb_idle_count got %0d want 0", cnt0); end
  endtask

  task automatic test_lsb();
    logic [3:0] exp_x = 4'b1100;
    data1 = 4'b1100;
    valid1 = 1'b1;
    step();
    valid1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++; if (x1 !== exp_x[i]) begin err++; $display("FAIL lsb_x%0d got %b want %b", i, x1, exp_x[i]); end
      step();
    end
    cmp++; if (wd1 !== 1'b1) begin err++; $display("FAIL lsb_done got %b want 1", wd1); end
    cmp++; if (sr1 !== 4'b0011) begin err++; $display("FAIL lsb_sr got %b want 0011", sr1); end
    step();
    step();
    cmp++; if (ready1 !== 1'b1) begin err++; $display("FAIL lsb_ready got %b want 1", ready1); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] w1 = 4'hA;
    logic [3:0] w2 = 4'h5;
    data0 = w1;
    valid0 = 1'b1;
    step();
    data0 = w2;
    for (int i = 0; i < 4; i++) begin
      cmp++; if (x0 !== w1[3-i]) begin err++; $display("FAIL b2b_w1_x%0d got %b want %b", i, x0, w1[3-i]); end
      step();
    end
    cmp++; if (sr0 !== 4'hA) begin err++; $display("FAIL b2b_sr1 got %h want a", sr0); end
    step();
    step();
    cmp++; if (ready0 !== 1'b1) begin err++; $display("FAIL b2b_ready got %b want 1", ready0); end
    step();
    valid0 = 1'b0;
    cmp++; if (acc_last - acc_prev !== 7) begin err++; $display("FAIL b2b_period got %0d want 7", acc_last - acc_prev); end
    for (int i = 0; i < 4; i++) begin
      cmp++; if (x0 !== w2[3-i]) begin err++; $display("FAIL b2b_w2_x%0d got %b want %b", i, x0, w2[3-i]); end
      step();
    end
    cmp++; if (wd0 !== 1'b1) begin err++; $display("FAIL b2b_done got %b want 1", wd0); end
    cmp++; if (sr0 !== 4'h5) begin err++; $display("FAIL b2b_sr2 got %h want 5", sr0); end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    logic [3:0] w = 4'b0110;
    int dones = 0;
    data0 = 4'b1011;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    step();
    reset = 1'b1;
    step();
    cmp++; if (en0 !== 1'b0) begin err++; $display("FAIL mid_en got %b want 0", en0); end
    cmp++; if (cnt0 !== 3'd0) begin err++; $display("FAIL mid_count got %0d want 0", cnt0); end
    cmp++; if (ready0 !== 1'b0) begin err++; $display("FAIL mid_ready got %b want 0", ready0); end
    cmp++; if (busy0 !== 1'b0) begin err++; $display("FAIL mid_busy got %b want 0", busy0); end
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (wd0) dones++;
      step();
    end
    cmp++; if (dones !== 0) begin err++; $display("FAIL mid_no_done got %0d pulses want 0", dones); end
    data0 = w;
    valid0 = 1'b1;
    step();
    valid0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmp++; if (x0 !== w[3-i]) begin err++; $display("FAIL mid_new_x%0d got %b want %b", i, x0, w[3-i]); end
      step();
    end
    cmp++; if (wd0 !== 1'b1) begin err++; $display("FAIL mid_new_done got %b want 1", wd0); end
    cmp++; if (sr0 !== w) begin err++; $display("FAIL mid_new_sr got %b want %b", sr0, w); end
    step();
    step();
  endtask

  task automatic test_gap0();
    int acc[4];
    int wds[4];
    int na = 0;
    int nw = 0;
    data2 = 4'b1001;
    valid2 = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (ready2 && na < 4) begin acc[na] = n; na++; end
      if (wd2 && nw < 4) begin wds[nw] = n; nw++; end
      step();
    end
    valid2 = 1'b0;
    cmp++; if (na < 2 || nw < 2) begin err++; $display("FAIL gap0_events got %0d accepts %0d dones want >=2 each", na, nw); end
    else begin
      cmp++; if (acc[1] - acc[0] !== 6) begin err++; $display("FAIL gap0_accept_period got %0d want 6", acc[1] - acc[0]); end
      cmp++; if (wds[1] - wds[0] !== 6) begin err++; $display("FAIL gap0_done_period got %0d want 6", wds[1] - wds[0]); end
      cmp++; if (wds[0] - acc[0] !== 5) begin err++; $display("FAIL gap0_latency got %0d want 5", wds[0] - acc[0]); end
    end
    step();
    step();
    step();
    step();
    step();
    step();
    step();
    cmp++; if ({busy2, ready2} !== 2'b01) begin err++; $display("FAIL gap0_idle got %b want 01", {busy2, ready2}); end
  endtask

  initial begin
    test_reset();
    test_msb();
    test_lsb();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule

// File: doc/sr_load_sequencer.md
# sr_load_sequencer

Controller that feeds the team's serial-in 4-bit shift register one bit per cycle. It accepts a parallel word over a valid/ready handshake and drives the register's serial input (x_o) plus a shift enable. It then strobes word_done_o in the cycle the downstream register's parallel output (sr_o) holds the complete word. It sits between a parallel producer and one or more serial-in shift registers, and owns all bit ordering and spacing between words.

## Interface
- WIDTH, 4, word length in bits; ≥2.
- LSB_FIRST, 0, 0 = MSB of the word shifted first, 1 = LSB first.
- GAP, 1, idle cycles inserted after each word before ready_o reasserts; 0 allowed.
- One clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- data_i  in  WIDTH  word to serialize; sampled only on handshake.
- valid_i  in  1  producer has a word.
- ready_o  out  1  sequencer can accept a word.
- x_o  out  1  serial bit for the downstream register's x_i.
- shift_en_o  out  1  downstream register captures x_o on the next rising edge when high.
- word_done_o  out  1  one-cycle pulse: downstream sr_o now holds the full word.
- busy_o  out  1  high from the cycle after accept through the end of the GAP state.
- count_o  out  $clog2(WIDTH+1)  bits of the current word already presented.

## Operation
- FSM states are IDLE, SHIFT, DONE and GAP.
- IDLE:
  - ready_o = 1 (forced 0 while reset is high).
  - Handshake = valid_i && ready_o at a rising edge.
  - On handshake: load data_i into the hold register, clear the counter, go to SHIFT.
- SHIFT:
  - shift_en_o = 1; x_o = current bit of the hold register.
  - Each edge advances the hold register by one bit and increments the counter.
  - After WIDTH bits, go to DONE.
- DONE:
  - Lasts one cycle; word_done_o = 1.
  - Next state is GAP if GAP > 0, else IDLE.
- GAP:
  - Counts GAP cycles, then goes to IDLE.
- Bit order:
  - LSB_FIRST = 0: bit WIDTH-1 first, bit 0 last.
  - LSB_FIRST = 1: bit 0 first, bit WIDTH-1 last.
- Outside SHIFT:
  - shift_en_o = 0 and x_o = 0.
  - data_i and valid_i are ignored when ready_o = 0; a held valid_i is accepted at the next IDLE cycle.
- count_o:
  - 0 in IDLE.
  - In SHIFT, equals the index of the bit currently presented (0..WIDTH-1).
  - Equals WIDTH in DONE and GAP.
- Reset, including mid-word:
  - Next state is IDLE; hold register and counters cleared.
  - No word_done_o pulse is produced for an aborted word.
- Reset values: ready_o 1 (after reset deasserts), x_o 0, shift_en_o 0, word_done_o 0, busy_o 0, count_o 0.
- Counter widths: the bit counter is $clog2(WIDTH+1) bits; the gap counter is $clog2(GAP+1) bits, with a minimum of 1.

## Timing
- Handshake at edge k → SHIFT occupies cycles k+1 .. k+WIDTH, one bit per cycle.
- word_done_o is high in cycle k+WIDTH+1; downstream sr_o is valid in that same cycle.
- ready_o reasserts in cycle k+WIDTH+2+GAP.
- Minimum word period is WIDTH+2+GAP cycles; with WIDTH=4, GAP=1 that is 7 cycles.
- All outputs are decoded from registered state and hold bits only. There is no combinational path from valid_i or data_i to any output other than through the state.
- Reset asserted in any cycle → all outputs take their reset values in the cycle after that edge.

## Structure
- Package sr_seq_pkg holds:
  - the state typedef (enum logic [1:0] {IDLE, SHIFT, DONE, GAP});
  - localparam helpers for the counter widths.
- Sub-module piso_shifter:
  - Contains the hold register: parallel load, one-bit advance, LSB_FIRST select, current-bit output.
  - The FSM and counters stay in sr_load_sequencer.
- The bench instantiates the existing 4-bit shift register downstream, with its x_i driven by x_o, gated by shift_en_o.

## Test plan
- Reset then idle: reset high for 2 cycles, then low → ready_o=1, busy_o=0, x_o=0, shift_en_o=0, count_o=0.
- MSB-first word: WIDTH=4, LSB_FIRST=0, data_i=4'b1011 accepted at edge k.
  - x_o = 1,0,1,1 in cycles k+1..k+4.
  - word_done_o high at k+5; downstream sr_o=4'b1011.
- LSB-first word: LSB_FIRST=1, data_i=4'b1100.
  - x_o = 0,0,1,1.
  - Downstream sr_o=4'b0011 at word_done_o (its MSB-first shift sees the reversed order).
- Back-to-back: valid_i held high with 4'hA then 4'h5, GAP=1.
  - Second accept occurs exactly 7 cycles after the first.
  - data_i changes during SHIFT do not alter x_o.
- Reset mid-word: reset asserted in the 2nd SHIFT cycle.
  - Next cycle: shift_en_o=0, count_o=0, ready_o=0 while reset is high.
  - No word_done_o pulse.
  - A new word after reset shifts cleanly.
- GAP=0: two words back-to-back → accept period of 6 cycles; word_done_o pulses are 6 cycles apart.
